// File: rtl/hamming_encode_ctrl.sv
// hamming_encode_ctrl: walks a block of 11-bit data words in byte memory,
// presents each word to an external combinational Hamming (16,11) parity
// encoder, and writes the assembled 16-bit codeword back as two bytes.
// Byte-order of the destination codeword (low byte first):
//   low  = {b4, b3, b2, p4, b1, p2, p1, p16}
//   high = {b11, b10, b9, b8, b7, b6, b5, p8}
module hamming_encode_ctrl #(
  parameter int unsigned NUM_WORDS = 15,
  parameter int unsigned SRC_BASE  = 0,
  parameter int unsigned DST_BASE  = 30,
  parameter int unsigned AW        = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  output logic          Ack,
  output logic          Busy,
  output logic [AW-1:0] MemAddr,
  output logic          MemWrEn,
  output logic [7:0]    MemWrData,
  input  logic [7:0]    MemRdData,
  output logic [7:0]    EncA,
  output logic [7:0]    EncB,
  input  logic [4:0]    EncParity
);

  localparam int unsigned IDX_W = 4;

  localparam logic [IDX_W-1:0] LP_LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [AW-1:0]    LP_SRC      = AW'(SRC_BASE);
  localparam logic [AW-1:0]    LP_DST      = AW'(DST_BASE);
  localparam logic [AW-1:0]    LP_ONE      = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_LO  = 3'd1,
    S_RD_HI  = 3'd2,
    S_CAP_HI = 3'd3,
    S_WR_LO  = 3'd4,
    S_WR_HI  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [7:0]           r_lo_q;
  // Only b11..b9 of the source high byte are meaningful; the rest is
  // dropped at capture since it can never reach the encoder.
  logic [2:0]           r_hi_q;
  logic                 r_ack;
  logic                 r_busy;
  logic                 r_wr_en;
  logic [AW-1:0]        r_addr;

  logic [IDX_W-1:0]     w_idx_inc;
  logic [AW-1:0]        w_src_cur;
  logic [AW-1:0]        w_src_nxt;
  logic [AW-1:0]        w_dst_cur;
  logic [7:0]           w_cw_lo;
  logic [7:0]           w_cw_hi;
  logic [7:0]           w_wr_data;

  // Word-index arithmetic; addresses wrap modulo 2^AW by construction.
  assign w_idx_inc = r_idx + IDX_W'(1);
  assign w_src_cur = LP_SRC + AW'({r_idx, 1'b0});
  assign w_src_nxt = LP_SRC + AW'({w_idx_inc, 1'b0});
  assign w_dst_cur = LP_DST + AW'({r_idx, 1'b0});

  // Codeword bytes assembled from the captured data and encoder parity.
  // EncParity = {p16, p8, p4, p2, p1}; r_lo_q = {b8..b1}; r_hi_q = {b11..b9}.
  assign w_cw_lo = {r_lo_q[3], r_lo_q[2], r_lo_q[1], EncParity[2],
                    r_lo_q[0], EncParity[1], EncParity[0], EncParity[4]};
  assign w_cw_hi = {r_hi_q[2], r_hi_q[1], r_hi_q[0], r_lo_q[7],
                    r_lo_q[6], r_lo_q[5], r_lo_q[4], EncParity[3]};

  // Sequencer: state, index, capture registers and registered strobes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_lo_q  <= '0;
      r_hi_q  <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_wr_en <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_ack   <= 1'b0;
      r_wr_en <= 1'b0;
      r_addr  <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_state <= S_RD_LO;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_addr  <= LP_SRC;
          end
        end
        S_RD_LO: begin
          r_state <= S_RD_HI;
          r_addr  <= w_src_cur + LP_ONE;
        end
        S_RD_HI: begin
          r_state <= S_CAP_HI;
          r_lo_q  <= MemRdData;
        end
        S_CAP_HI: begin
          r_state <= S_WR_LO;
          r_hi_q  <= MemRdData[2:0];
          r_wr_en <= 1'b1;
          r_addr  <= w_dst_cur;
        end
        S_WR_LO: begin
          r_state <= S_WR_HI;
          r_wr_en <= 1'b1;
          r_addr  <= w_dst_cur + LP_ONE;
        end
        S_WR_HI: begin
          if (r_idx == LP_LAST_IDX) begin
            r_state <= S_DONE;
            r_ack   <= 1'b1;
          end else begin
            r_state <= S_RD_LO;
            r_idx   <= w_idx_inc;
            r_addr  <= w_src_nxt;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Write byte is decoded from state so the encoder adds no latency.
  always_comb begin
    w_wr_data = 8'h00;
    unique case (r_state)
      S_WR_LO: w_wr_data = w_cw_lo;
      S_WR_HI: w_wr_data = w_cw_hi;
      default: w_wr_data = 8'h00;
    endcase
  end

  assign Ack       = r_ack;
  assign Busy      = r_busy;
  assign MemWrEn   = r_wr_en;
  assign MemAddr   = r_addr;
  assign MemWrData = w_wr_data;
  assign EncA      = {5'b0, r_hi_q};
  assign EncB      = r_lo_q;

endmodule

// File: doc/hamming_encode_ctrl.md
# hamming_encode_ctrl

Sequencing controller for the combinational Hamming (16,11) parity encoder. On `Start` it walks a block of 11-bit data words in data memory, feeds each word's two bytes to the encoder, and assembles the 16-bit codeword. It writes each codeword back to memory as two bytes, then pulses `Ack`. It sits between the data memory port and the parity encoder, and owns both for the duration of a run.

## Interface
- `NUM_WORDS`, 15: data words processed per run (1..15).
- `SRC_BASE`, 0: byte address of word 0's low byte.
- `DST_BASE`, 30: byte address of codeword 0's low byte.
- `AW`, 8: memory address width.

Ports:
- `Clk` in 1: the only clock; all state updates on its rising edge.
- `Reset` in 1: synchronous, active-high.
- `Start` in 1: run request; sampled only in IDLE.
- `Ack` out 1: one-cycle pulse when a run completes.
- `Busy` out 1: high in every state except IDLE.
- `MemAddr` out AW: memory address.
- `MemWrEn` out 1: memory write strobe.
- `MemWrData` out 8: write byte.
- `MemRdData` in 8: read byte, valid the cycle after its address is presented.
- `EncA` out 8: encoder high input, `{5'b0, b11, b10, b9}`.
- `EncB` out 8: encoder low input, `{b8..b1}`.
- `EncParity` in 5: encoder result `{p16, p8, p4, p2, p1}`, combinational from `EncA`/`EncB`.

## Operation
- Memory layout, word i:
  - Source: low byte `{b8..b1}` at `SRC_BASE+2i`; high byte at `SRC_BASE+2i+1`, where only bits [2:0] (`b11..b9`) are meaningful.
  - Destination: low byte `{b4, b3, b2, p4, b1, p2, p1, p16}` at `DST_BASE+2i`; high byte `{b11, b10, b9, b8, b7, b6, b5, p8}` at `DST_BASE+2i+1`.
- Internal state: 4-bit word index `idx`, 8-bit `lo_q` and `hi_q` capture registers.
- `EncA` is driven from `{5'b0, hi_q[2:0]}` and `EncB` from `lo_q`. Source bits [7:3] of the high byte never reach the encoder.
- FSM states and transitions:
  - IDLE: `Start` → RD_LO, with `idx`=0.
  - RD_LO: `MemAddr`=`SRC_BASE+2*idx` → RD_HI.
  - RD_HI: `MemAddr`=`SRC_BASE+2*idx+1`; `lo_q`←`MemRdData` → CAP_HI.
  - CAP_HI: `hi_q`←`MemRdData` → WR_LO.
  - WR_LO: `MemWrEn`=1, `MemAddr`=`DST_BASE+2*idx`, `MemWrData`=low codeword byte → WR_HI.
  - WR_HI: `MemWrEn`=1, `MemAddr`=`DST_BASE+2*idx+1`, `MemWrData`=high codeword byte.
    - If `idx`==`NUM_WORDS-1` → DONE.
    - Otherwise `idx`←`idx+1` → RD_LO.
  - DONE: `Ack`=1 → IDLE.
- Address arithmetic is AW bits wide and wraps modulo 2^AW with no error flag.
- `Start` outside IDLE is ignored, and it does not queue. `Start` held high through DONE begins a new run on the IDLE cycle that follows.
- `MemWrEn` is high only in WR_LO and WR_HI. The controller never writes the source region unless the parameters make the two regions overlap; that case is not checked.

## Timing
- Reset (any state, including mid-run) drives the next state to IDLE and clears to 0:
  - `idx`, `lo_q`, `hi_q`
  - `Ack`, `Busy`, `MemWrEn`, `MemAddr`, `MemWrData`, `EncA`, `EncB`
- A write interrupted by reset is not completed; a codeword half-written before reset stays half-written.
- Outputs are registered or decoded from state; `MemWrData` is decoded from state, `lo_q`, `hi_q` and `EncParity`. In IDLE and DONE, `MemAddr` and `MemWrData` are 0.
- Per word: 5 cycles (RD_LO, RD_HI, CAP_HI, WR_LO, WR_HI).
- `Start` sampled high in IDLE at edge t: RD_LO occupies cycle t+1, and `Ack` is high during cycle t+1+5*`NUM_WORDS` (cycle t+76 at defaults).
- `Busy` rises with RD_LO and falls on the return to IDLE.
- The encoder path is combinational from `hi_q`/`lo_q` to `MemWrData` within WR_LO/WR_HI; there is no added latency.

## Test plan
- All-zero source (mem[0..29]=0x00), Start → mem[30..59] all 0x00; Ack exactly 76 cycles after Start is sampled; exactly 30 writes, addresses 30..59 in order.
- Word 0 = 0x001 (mem[0]=0x01, mem[1]=0x00) → mem[30]=0x0F, mem[31]=0x00.
- Word 0 = 0x7FF (mem[0]=0xFF, mem[1]=0x07) → mem[30]=0xFF, mem[31]=0xFF.
- Word 0 with junk upper bits (mem[0]=0x01, mem[1]=0xF8) → `EncA`=0x00 during WR_LO; mem[30]=0x0F, mem[31]=0x00.
- Random 15 words checked against a software Hamming (16,11) model, followed by a second Start → identical results, second Ack 76 cycles later; a Start pulse mid-run changes nothing.
- Reset asserted in WR_LO of word 5 → next cycle: IDLE, all outputs 0, no further writes; mem[40] is holding word 5's low byte and mem[41] unchanged; a new Start reruns from word 0.
